mux_nto1_rr: RTL and testbench



---
 rtl/mux_nto1_rr.sv | 86 ++++++++
 tb/tb_mux_nto1_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - N-to-1 registered stream mux with fixed-select and round-robin grant
module mux_nto1_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  g;
    logic [SELW-1:0]  rr_off;
    logic [SELW:0]    rr_sum;
    logic [SELW:0]    g_inc;
    logic [2*NCH-1:0] rot;
    logic             rr_found;
    logic             sel_ok;
    logic             gv;
    logic             load_en;
    logic             xfer;

    assign load_en = !out_valid || out_ready;

    // Rotate the valid vector so bit 0 is the channel at ptr; the lowest set bit wins.
    always_comb begin
        rot      = {in_valid, in_valid} >> ptr;
        rr_off   = '0;
        rr_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_off   = SELW'(i);
                rr_found = 1'b1;
            end
        end
        rr_sum = {1'b0, ptr} + {1'b0, rr_off};
        if (rr_sum >= (SELW+1)'(NCH)) begin
            rr_sum = rr_sum - (SELW+1)'(NCH);
        end
    end

    always_comb begin
        sel_ok = ({1'b0, sel} < (SELW+1)'(NCH));
        if (mode) begin
            g  = rr_sum[SELW-1:0];
            gv = rr_found;
        end else begin
            g  = sel;
            gv = sel_ok && in_valid[sel];
        end
    end

    assign xfer     = load_en && gv;
    assign in_ready = (xfer && rst_n) ? (NCH'(1) << g) : '0;
    assign g_inc    = {1'b0, g} + (SELW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_data  <= in_data[g*WIDTH +: WIDTH];
                out_ch    <= g;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= (g_inc == (SELW+1)'(NCH)) ? '0 : g_inc[SELW-1:0];
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb/tb_mux_nto1_rr.sv - randomized scoreboard bench for mux_nto1_rr
module tb_mux_nto1_rr;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 mode = 1'b0;
    logic [SELW-1:0]      sel = '0;
    logic [NCH*WIDTH-1:0] in_data = '0;
    logic [NCH-1:0]       in_valid = '0;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready = 1'b0;

    logic                 mode6 = 1'b0;
    logic [2:0]           sel6 = '0;
    logic [6*WIDTH-1:0]   in_data6 = 48'h665544332211;
    logic [5:0]           in_valid6 = '0;
    logic [5:0]           in_ready6;
    logic [WIDTH-1:0]     out_data6;
    logic [2:0]           out_ch6;
    logic                 out_valid6;

    mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_rr #(.WIDTH(WIDTH), .NCH(6), .SELW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
        .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(1'b1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } beat_t;

    beat_t          q[$];
    logic [7:0]     chan[NCH];
    int             m_ptr = 0;
    bit             m_full = 1'b0;
    int             total = 0;
    int             bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference grant: fixed = sel if in range and valid; rr = valid channel nearest ptr going upward.
    function automatic void ref_grant(input bit md, input int s, input logic [NCH-1:0] v,
                                      input int p, output int gg, output bit ok);
        int best;
        gg   = 0;
        ok   = 1'b0;
        best = NCH;
        if (!md) begin
            if (s < NCH && v[s]) begin
                gg = s;
                ok = 1'b1;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (v[k] && ((k - p + NCH) % NCH) < best) begin
                    best = (k - p + NCH) % NCH;
                    gg   = k;
                    ok   = 1'b1;
                end
            end
        end
    endfunction

    task automatic step(input bit md, input int s, input logic [NCH-1:0] v, input bit ordy);
        int gg;
        bit ok;
        bit le;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("ptr", 32'(dut.ptr), 32'(m_ptr));
        mode      = md;
        sel       = SELW'(s);
        in_valid  = v;
        out_ready = ordy;
        for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = chan[k];
        #1;
        ref_grant(md, s, v, m_ptr, gg, ok);
        le = !m_full || ordy;
        chk("in_ready", 32'(in_ready), (le && ok) ? (32'd1 << gg) : 32'd0);
        if (le) begin
            if (ok) begin
                q.push_back('{chan[gg], gg});
                if (md) m_ptr = (gg + 1) % NCH;
            end
            m_full = ok;
        end
    endtask

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_ch), 32'hffff_ffff);
                end else begin
                    b = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(b.d));
                    chk("out_ch", 32'(out_ch), 32'(b.c));
                end
            end
        end
    end

    initial begin : stim
        chan[0] = 8'h11; chan[1] = 8'h22; chan[2] = 8'h33; chan[3] = 8'h44;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < NCH; s++) step(1'b0, s, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 0, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 4'b1010, 1'b1);
        step(1'b1, 0, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 0, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 0, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2, 4'b1011, 1'b1);
        step(1'b0, 3, 4'b1011, 1'b1);
        step(1'b0, 3, 4'b1011, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, 0, 4'hF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_ch", 32'(out_ch), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        m_ptr    = 0;
        m_full   = 1'b0;
        in_valid = '0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 0, 4'hF, 1'b1);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH; k++) chan[k] = 8'($urandom);
            step(1'($urandom), int'($urandom_range(0, NCH - 1)), 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 4'h0, 1'b1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        @(posedge clk);
        #1;
        mode6 = 1'b0; sel6 = 3'd5; in_valid6 = 6'h3F;
        #1;
        chk("n6_sel5_ready", 32'(in_ready6), 32'h20);
        sel6 = 3'd6;
        #1;
        chk("n6_sel6_ready", 32'(in_ready6), 32'h00);
        mode6 = 1'b1; in_valid6 = 6'b100001;
        #1;
        chk("n6_rr_ready0", 32'(in_ready6), 32'h01);
        @(posedge clk);
        #1;
        chk("n6_out_ch0", 32'(out_ch6), 32'd0);
        chk("n6_ptr1", 32'(dut6.ptr), 32'd1);
        chk("n6_rr_ready5", 32'(in_ready6), 32'h20);
        @(posedge clk);
        #1;
        chk("n6_out_ch5", 32'(out_ch6), 32'd5);
        chk("n6_out_data5", 32'(out_data6), 32'h66);
        chk("n6_ptr_wrap", 32'(dut6.ptr), 32'd0);
        mode6 = 1'b0; sel6 = 3'd6;
        @(posedge clk);
        #1;
        chk("n6_oor_ready", 32'(in_ready6), 32'h00);
        @(posedge clk);
        #1;
        chk("n6_oor_valid", 32'(out_valid6), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
